// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB slave front end for the SRAM controller. Turns pipelined AHB transfers
// into single-cycle accesses on two 32-bit SRAM banks. Each bank is four
// byte-wide macros. One wait state is inserted for a write followed directly
// by a read. A two-cycle ERROR is returned for illegal transfers and for any
// transfer while BIST owns the arrays.
//
// Ports
//   hclk, hresetn  : bus clock, asynchronous active-low reset
//   hsel .. hwdata : AHB slave inputs (hburst is ignored, beats are independent)
//   bist_en        : BIST owns the arrays, every new accept errors
//   hready_resp    : slave ready
//   hresp          : OKAY=00, ERROR=01
//   hrdata         : read data, zero outside a read data phase
//   sram_addr      : macro word address
//   sram_wdata     : write data to the macros
//   sram_cen_n     : per-bank chip enable, active low
//   sram_wen_n     : per-byte-lane write enable, active low
//   sram_q0/1      : bank read data, valid one cycle after the enabled read
// ---------------------------------------------------------------------------
module ahb_sram_slave_if #(
  parameter int unsigned SRAM_AW = 13,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic               hready,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               bist_en,
  output logic               hready_resp,
  output logic [1:0]         hresp,
  output logic [DATA_W-1:0]  hrdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic [1:0]         sram_cen_n,
  output logic [3:0]         sram_wen_n,
  input  logic [DATA_W-1:0]  sram_q0,
  input  logic [DATA_W-1:0]  sram_q1
);

  // haddr[BANK_BIT] selects the bank, haddr[BANK_BIT-1:2] is the word address
  localparam int unsigned BANK_BIT = SRAM_AW + 2;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_HOLD = 3'd2,
    S_RD      = 3'd3,
    S_ERR1    = 3'd4,
    S_ERR2    = 3'd5
  } state_t;

  state_t             r_state;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_bank;
  logic [3:0]         r_mask;

  logic               w_accept;
  logic               w_illegal;
  logic               w_rd_cand;
  logic               w_open;
  logic               w_take;
  logic               w_rd_issue;
  logic               w_bank;
  logic [SRAM_AW-1:0] w_addr;
  logic [3:0]         w_mask;
  state_t             w_acc_state;
  logic               w_unused;

  assign w_unused = ^{hburst, haddr[31:BANK_BIT+1]};

  assign w_addr    = haddr[BANK_BIT-1:2];
  assign w_bank    = haddr[BANK_BIT];
  assign w_accept  = hsel & hready & htrans[1];
  // Read presented on the bus regardless of hready; used to stall after a write
  assign w_rd_cand = hsel & htrans[1] & ~hwrite;

  // Size / alignment / BIST legality of the address phase
  always_comb begin
    w_illegal = bist_en;
    if (hsize > 3'd2)                             w_illegal = 1'b1;
    if ((hsize == 3'd1) && haddr[0])              w_illegal = 1'b1;
    if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) w_illegal = 1'b1;
  end

  // Byte-lane mask of the address phase
  always_comb begin
    w_mask = 4'hF;
    case (hsize)
      3'd0:    w_mask = 4'b0001 << haddr[1:0];
      3'd1:    w_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'hF;
    endcase
  end

  // State that the current accept (or lack of one) leads to
  always_comb begin
    w_acc_state = S_IDLE;
    if (w_accept) begin
      if (w_illegal)   w_acc_state = S_ERR1;
      else if (hwrite) w_acc_state = S_WR;
      else             w_acc_state = S_RD;
    end
  end

  // Cycles in which a new address phase may be taken; a write data phase
  // facing a read is closed because the read would collide with the write
  assign w_open = (r_state == S_IDLE) || (r_state == S_RD) ||
                  (r_state == S_WR_HOLD) || ((r_state == S_WR) && !w_rd_cand);
  assign w_take     = w_open & w_accept;
  assign w_rd_issue = w_take & ~w_illegal & ~hwrite;

  // State and captured address-phase information
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_bank  <= 1'b0;
      r_mask  <= 4'h0;
    end else begin
      case (r_state)
        S_ERR1:  r_state <= S_ERR2;
        S_ERR2:  r_state <= S_IDLE;
        S_WR:    r_state <= w_rd_cand ? S_WR_HOLD : w_acc_state;
        default: r_state <= w_acc_state;
      endcase
      if (w_take && !w_illegal) begin
        r_addr <= w_addr;
        r_bank <= w_bank;
        r_mask <= w_mask;
      end
    end
  end

  // Bus response and SRAM strobes; everything is forced idle under reset so
  // no macro is enabled while hresetn is low
  always_comb begin
    hready_resp = 1'b1;
    hresp       = RESP_OKAY;
    hrdata      = '0;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_cen_n  = 2'b11;
    sram_wen_n  = 4'hF;
    if (hresetn) begin
      case (r_state)
        S_WR: begin
          sram_cen_n[r_bank] = 1'b0;
          sram_addr          = r_addr;
          sram_wdata         = hwdata;
          sram_wen_n         = ~r_mask;
          if (w_rd_cand) hready_resp = 1'b0;
        end
        S_RD: begin
          hrdata = r_bank ? sram_q1 : sram_q0;
        end
        S_ERR1: begin
          hready_resp = 1'b0;
          hresp       = RESP_ERROR;
        end
        S_ERR2: begin
          hresp = RESP_ERROR;
        end
        default: ;
      endcase
      // Read issue; never coincides with a write since w_open excludes it
      if (w_rd_issue) begin
        sram_cen_n[w_bank] = 1'b0;
        sram_addr          = w_addr;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave_if
// Pipelined AHB master driving the slave against a byte-array memory model
// and transaction-level response rules; behavioural SRAM macros close the loop.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave_if;

  localparam int unsigned SRAM_AW = 13;
  localparam int unsigned DATA_W  = 32;

  logic               hclk = 1'b0;
  logic               hresetn;
  logic               hsel;
  logic [31:0]        haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [2:0]         hburst;
  logic               hready;
  logic [DATA_W-1:0]  hwdata;
  logic               bist_en;
  logic               hready_resp;
  logic [1:0]         hresp;
  logic [DATA_W-1:0]  hrdata;
  logic [SRAM_AW-1:0] sram_addr;
  logic [DATA_W-1:0]  sram_wdata;
  logic [1:0]         sram_cen_n;
  logic [3:0]         sram_wen_n;
  logic [DATA_W-1:0]  sram_q0;
  logic [DATA_W-1:0]  sram_q1;

  always #5 hclk = ~hclk;

  // Single slave on the bus: the master sees this slave's ready
  assign hready = hready_resp;

  ahb_sram_slave_if #(.SRAM_AW(SRAM_AW), .DATA_W(DATA_W)) u_dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hready(hready), .hwdata(hwdata), .bist_en(bist_en),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_cen_n(sram_cen_n),
    .sram_wen_n(sram_wen_n), .sram_q0(sram_q0), .sram_q1(sram_q1)
  );

  // Behavioural SRAM banks
  logic [31:0] mem0 [0:8191];
  logic [31:0] mem1 [0:8191];

  always @(posedge hclk) begin
    if (!sram_cen_n[0]) begin
      if (sram_wen_n == 4'hF) sram_q0 <= mem0[sram_addr];
      else for (int i = 0; i < 4; i++)
        if (!sram_wen_n[i]) mem0[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
    if (!sram_cen_n[1]) begin
      if (sram_wen_n == 4'hF) sram_q1 <= mem1[sram_addr];
      else for (int i = 0; i < 4; i++)
        if (!sram_wen_n[i]) mem1[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
  end

  // Reference memory: 64 KB byte array addressed by haddr[15:0]
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] wdata;
    logic        bist;
    bit          term;
  } xfer_t;

  xfer_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit f_real(input xfer_t x);
    return x.hsel && x.htrans[1];
  endfunction

  function automatic bit f_legal(input xfer_t x);
    if (!f_real(x) || x.bist || x.hsize > 3'd2) return 1'b0;
    if (x.hsize == 3'd1 && x.haddr[0]) return 1'b0;
    if (x.hsize == 3'd2 && x.haddr[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  // Lanes covered by a naturally aligned transfer of 2**hsize bytes
  function automatic logic [3:0] f_lanes(input xfer_t x);
    int nb;
    int lo;
    nb = 1 << x.hsize;
    lo = int'(x.haddr[1:0]);
    lo = lo - (lo % nb);
    return 4'(((1 << nb) - 1) << lo);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    return {ref_mem[16'(b + 16'd3)], ref_mem[16'(b + 16'd2)],
            ref_mem[16'(b + 16'd1)], ref_mem[b]};
  endfunction

  function automatic xfer_t mk_idle(input bit term);
    xfer_t x;
    x.hsel = 1'b0; x.htrans = 2'b00; x.hwrite = 1'b0; x.hsize = 3'd0;
    x.haddr = 32'h0; x.wdata = 32'h0; x.bist = 1'b0; x.term = term;
    return x;
  endfunction

  function automatic xfer_t mk(input bit wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] d, input bit bist);
    xfer_t x;
    x.hsel = 1'b1; x.htrans = 2'b10; x.hwrite = wr; x.hsize = sz;
    x.haddr = a; x.wdata = d; x.bist = bist; x.term = 1'b0;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t       x;
    logic [12:0] w;
    int          k;
    k = $urandom_range(0, 9);
    w = ($urandom_range(0, 5) == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
    x = mk(1'($urandom), 3'd2, {16'($urandom), 1'($urandom), w, 2'($urandom)},
           $urandom, ($urandom_range(0, 11) == 0));
    if (k < 2) begin
      case ($urandom_range(0, 2))
        0:       x.hsel   = 1'b0;
        1:       x.htrans = 2'b00;
        default: x.htrans = 2'b01;
      endcase
    end else begin
      x.htrans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
      x.hsize  = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(3, 7))
                                               : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) begin
        if (x.hsize == 3'd1) x.haddr[0] = 1'b0;
        if (x.hsize >= 3'd2) x.haddr[1:0] = 2'b00;
      end
    end
    return x;
  endfunction

  function automatic xfer_t next_ap();
    if (q.size() > 0) return q.pop_front();
    return mk_idle(1'b1);
  endfunction

  task automatic drive(input xfer_t ap, input bit dpv, input xfer_t dp);
    hsel    = ap.hsel;
    htrans  = ap.htrans;
    hwrite  = ap.hwrite;
    hsize   = ap.hsize;
    haddr   = ap.haddr;
    bist_en = ap.bist;
    hburst  = 3'($urandom);
    hwdata  = (dpv && dp.hwrite && f_real(dp)) ? dp.wdata : $urandom;
  endtask

  // Run the queued transfers as a pipelined master; called just after a posedge
  task automatic run_queue();
    xfer_t       ap, dp, nx;
    bit          dpv, rdy, err, exp_err, exp_rd, wr_now, rd_acc;
    int          dcyc, exp_waits;
    logic [31:0] exp_data;
    logic [1:0]  exp_cen;
    logic [3:0]  exp_wen;
    logic [12:0] exp_addr;
    ap = next_ap(); dp = mk_idle(1'b0); dpv = 1'b0; dcyc = 0; exp_waits = 0;
    exp_err = 1'b0; exp_rd = 1'b0; exp_data = 32'h0;
    while (!(ap.term && !dpv)) begin
      drive(ap, dpv, dp);
      @(negedge hclk);
      rdy = hready_resp;
      err = (hresp == 2'b01);
      chk("hready_resp", 32'(hready_resp), 32'(!dpv || dcyc >= exp_waits));
      chk("hresp", 32'(hresp), 32'(dpv && exp_err));
      if (dpv && exp_rd) chk("hrdata", hrdata, exp_data);
      else               chk("hrdata_zero", hrdata, 32'h0);
      // Expected macro strobes from the transaction timing rules
      exp_cen = 2'b11; exp_wen = 4'hF; exp_addr = 13'h0;
      wr_now = dpv && dp.hwrite && f_legal(dp) && (dcyc == 0);
      rd_acc = f_legal(ap) && !ap.hwrite && (!dpv || dcyc >= exp_waits);
      if (wr_now) begin
        exp_cen[dp.haddr[15]] = 1'b0;
        exp_wen  = ~f_lanes(dp);
        exp_addr = dp.haddr[14:2];
      end
      if (rd_acc) begin
        exp_cen[ap.haddr[15]] = 1'b0;
        exp_addr = ap.haddr[14:2];
      end
      chk("sram_cen_n", 32'(sram_cen_n), 32'(exp_cen));
      chk("sram_wen_n", 32'(sram_wen_n), 32'(exp_wen));
      if (exp_cen != 2'b11) chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      if (wr_now) chk("sram_wdata", sram_wdata, dp.wdata);
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (dpv) chk("wait_states", 32'(dcyc), 32'(exp_waits));
        nx  = next_ap();
        dp  = ap;
        dpv = !ap.term;
        ap  = nx;
        dcyc = 0;
        exp_err  = f_real(dp) && !f_legal(dp);
        exp_rd   = f_legal(dp) && !dp.hwrite;
        exp_data = ref_word(dp.haddr);
        exp_waits = 0;
        if (exp_err) exp_waits = 1;
        if (f_legal(dp) && dp.hwrite && ap.hsel && ap.htrans[1] && !ap.hwrite) exp_waits = 1;
        if (dpv && f_legal(dp) && dp.hwrite) begin
          for (int i = 0; i < 4; i++)
            if (f_lanes(dp)[i]) ref_mem[{dp.haddr[15:2], 2'(i)}] = dp.wdata[8*i +: 8];
        end
      end else begin
        dcyc++;
        // First ERROR cycle: park the pending transfer, drive IDLE through ERR2
        if (err && dpv) begin
          if (!ap.term) q.push_front(ap);
          ap = mk_idle(1'b0);
        end
        if (dcyc > 4) begin
          chk("stall_timeout", 32'(dcyc), 32'(exp_waits));
          q.delete();
          return;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h0;

    // Reset with a legal read on the bus: nothing may be enabled
    hresetn = 1'b0;
    drive(mk(1'b0, 3'd2, 32'h10, 32'h0, 1'b0), 1'b0, mk_idle(1'b0));
    #12;
    chk("rst_hready_resp", 32'(hready_resp), 32'h1);
    chk("rst_hresp",       32'(hresp),       32'h0);
    chk("rst_hrdata",      hrdata,           32'h0);
    chk("rst_cen",         32'(sram_cen_n),  32'h3);
    chk("rst_wen",         32'(sram_wen_n),  32'hF);
    chk("rst_addr",        32'(sram_addr),   32'h0);
    chk("rst_wdata",       sram_wdata,       32'h0);
    drive(mk_idle(1'b0), 1'b0, mk_idle(1'b0));
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Directed scenarios
    q.push_back(mk(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0));
    q.push_back(mk_idle(1'b0));
    q.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b0));
    q.push_back(mk_idle(1'b0));
    q.push_back(mk(1'b1, 3'd0, 32'h0000_8003, 32'hAA00_0000, 1'b0));
    q.push_back(mk_idle(1'b0));
    q.push_back(mk(1'b0, 3'd2, 32'h0000_8000, 32'h0, 1'b0));
    q.push_back(mk(1'b1, 3'd2, 32'h0000_0004, 32'h1234_5678, 1'b0));
    q.push_back(mk(1'b0, 3'd2, 32'h0000_0004, 32'h0, 1'b0));
    q.push_back(mk_idle(1'b0));
    q.push_back(mk(1'b0, 3'd2, 32'h0000_0002, 32'h0, 1'b0));
    q.push_back(mk_idle(1'b0));
    q.push_back(mk(1'b1, 3'd2, 32'h0000_0000, 32'h5555_AAAA, 1'b1));
    q.push_back(mk(1'b0, 3'd2, 32'h0000_0000, 32'h0, 1'b0));
    run_queue();

    // Randomized traffic
    for (int i = 0; i < 400; i++) q.push_back(rand_xfer());
    run_queue();

    // Reset asserted during a write data phase aborts the write
    drive(mk(1'b1, 3'd2, 32'h0000_0014, 32'h0, 1'b0), 1'b0, mk_idle(1'b0));
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    chk("wr_cycle_cen", 32'(sram_cen_n), 32'h2);
    #2;
    hresetn = 1'b0;
    #1;
    chk("arst_hready_resp", 32'(hready_resp), 32'h1);
    chk("arst_hresp",       32'(hresp),       32'h0);
    chk("arst_hrdata",      hrdata,           32'h0);
    chk("arst_cen",         32'(sram_cen_n),  32'h3);
    chk("arst_wen",         32'(sram_wen_n),  32'hF);
    chk("arst_addr",        32'(sram_addr),   32'h0);
    chk("arst_wdata",       sram_wdata,       32'h0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    q.push_back(mk(1'b0, 3'd2, 32'h0000_0014, 32'h0, 1'b0));
    q.push_back(mk_idle(1'b0));
    run_queue();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
